// File: rtl/load_queue.sv
// ============================================================================
// load_queue : in-order load FIFO between LSU issue and the load pipeline.
// The head is held back while its store collision is outstanding.
// Optional same-cycle bypass when empty: define LQ_BYPASS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

package load_queue_pkg;
  localparam int SQ_DEPTH      = 4;
  localparam int LOG2_SQ_DEPTH = $clog2(SQ_DEPTH);

  typedef struct packed {
    logic [7:0]               id;
    logic                     is_amo;
    logic [1:0]               size;
    logic                     store_collision;
    logic [LOG2_SQ_DEPTH-1:0] sq_index;
  } lq_entry_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  subunit;
    logic        discard;
  } addr_entry_t;
endpackage

module load_queue
  import load_queue_pkg::*;
#(
  parameter int LQ_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          push,
  input  logic [$bits(lq_entry_t)-1:0]   push_entry,
  input  logic [$bits(addr_entry_t)-1:0] push_addr,
  output logic                          full,
  input  logic                          sq_retire,
  input  logic [LOG2_SQ_DEPTH-1:0]      sq_retire_idx,
  output logic                          lq_valid,
  output logic [$bits(lq_entry_t)-1:0]   lq_entry,
  output logic [$bits(addr_entry_t)-1:0] lq_addr,
  input  logic                          lq_ack,
  output logic                          empty
);

  localparam int LOG2_LQ = $clog2(LQ_DEPTH);

  lq_entry_t             entry_q [LQ_DEPTH];
  addr_entry_t           addr_q  [LQ_DEPTH];
  logic [LQ_DEPTH-1:0]   blocked_q, blocked_d;
  logic [LOG2_LQ-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LOG2_LQ-1:0]    wr_ptr_q, wr_ptr_d;
  logic [LOG2_LQ:0]      count_q, count_d;

  lq_entry_t   push_e;
  addr_entry_t push_a;
  logic        head_ok;
  logic        bypass;
  logic        pop;
  logic        push_acc;
  logic        push_blocked;

  assign push_e = push_entry;
  assign push_a = push_addr;

  assign full    = (count_q == (LOG2_LQ+1)'(LQ_DEPTH));
  assign empty   = (count_q == '0);
  assign head_ok = !empty && !blocked_q[rd_ptr_q];

`ifdef LQ_BYPASS_EN
  assign bypass = empty && push && !push_e.store_collision && !flush;
`else
  assign bypass = 1'b0;
`endif

  assign lq_valid = head_ok || bypass;
  assign pop      = lq_ack && head_ok && !flush;
  // A bypassed load that is acked in the same cycle never occupies a slot.
  assign push_acc = push && !flush && (!full || pop) && !(bypass && lq_ack);
  assign push_blocked = push_e.store_collision &&
                        !(sq_retire && (sq_retire_idx == push_e.sq_index));

  always_comb begin
    blocked_d = blocked_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      if (sq_retire && (entry_q[i].sq_index == sq_retire_idx)) begin
        blocked_d[i] = 1'b0;
      end
    end
    if (push_acc) begin
      blocked_d[wr_ptr_q] = push_blocked;
      wr_ptr_d            = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + (LOG2_LQ+1)'(push_acc) - (LOG2_LQ+1)'(pop);
    if (flush) begin
      blocked_d = '0;
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      count_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blocked_q <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      blocked_q <= blocked_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc) begin
      entry_q[wr_ptr_q] <= push_e;
      addr_q[wr_ptr_q]  <= push_a;
    end
  end

  always_comb begin
    lq_entry = '0;
    lq_addr  = '0;
    if (bypass) begin
      lq_entry = push_entry;
      lq_addr  = push_addr;
    end else if (head_ok) begin
      lq_entry = entry_q[rd_ptr_q];
      lq_addr  = addr_q[rd_ptr_q];
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !lq_ack && !flush))
    else $warning("load_queue: push while full dropped");

endmodule

`default_nettype wire

// File: tb/tb_load_queue.sv
// Directed bench for load_queue with a scoreboard of expected head entries.
`default_nettype none

module tb_load_queue;
  import load_queue_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     flush = 1'b0;
  logic                     push = 1'b0;
  lq_entry_t                push_entry = '0;
  addr_entry_t              push_addr = '0;
  logic                     full;
  logic                     sq_retire = 1'b0;
  logic [LOG2_SQ_DEPTH-1:0] sq_retire_idx = '0;
  logic                     lq_valid;
  lq_entry_t                lq_entry;
  addr_entry_t              lq_addr;
  logic                     lq_ack = 1'b0;
  logic                     empty;

  int checks = 0;
  int errors = 0;

  lq_entry_t   exp_e[$];
  addr_entry_t exp_a[$];

  load_queue #(.LQ_DEPTH(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .push          (push),
    .push_entry    (push_entry),
    .push_addr     (push_addr),
    .full          (full),
    .sq_retire     (sq_retire),
    .sq_retire_idx (sq_retire_idx),
    .lq_valid      (lq_valid),
    .lq_entry      (lq_entry),
    .lq_addr       (lq_addr),
    .lq_ack        (lq_ack),
    .empty         (empty)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic set_push(input logic [7:0] id, input logic coll, input logic [1:0] sqi,
                          input logic expect_out);
    lq_entry_t   e;
    addr_entry_t a;
    e = '0;
    e.id = id;
    e.size = 2'b10;
    e.store_collision = coll;
    e.sq_index = sqi;
    a.addr = 32'h8000_0000 + {22'd0, id, 2'b00};
    a.subunit = id[1:0];
    a.discard = id[0];
    push = 1'b1;
    push_entry = e;
    push_addr = a;
    if (expect_out) begin
      exp_e.push_back(e);
      exp_a.push_back(a);
    end
  endtask

  // Monitor: every accepted head (valid && ack, not flushed) must match the scoreboard.
  always @(negedge clk) begin
    if (rst_n && !flush && lq_valid && lq_ack) begin
      checks++;
      if (exp_e.size() == 0) begin
        errors++;
        $display("FAIL head_unexpected actual_id=%0h required=none", lq_entry.id);
      end else begin
        lq_entry_t   e;
        addr_entry_t a;
        e = exp_e.pop_front();
        a = exp_a.pop_front();
        if (lq_entry !== e || lq_addr !== a) begin
          errors++;
          $display("FAIL head_data actual_id=%0h addr=%0h required_id=%0h addr=%0h",
                   lq_entry.id, lq_addr.addr, e.id, a.addr);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #2;
    chk("reset_empty", 64'(empty), 64'd1);
    chk("reset_full", 64'(full), 64'd0);
    chk("reset_valid", 64'(lq_valid), 64'd0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Fill to full, overflow push ignored, then drain in order
    for (int i = 0; i < 4; i++) begin
      set_push(8'(i), 1'b0, 2'd0, 1'b1);
      cyc();
    end
    set_push(8'd4, 1'b0, 2'd0, 1'b0);
    neg();
    chk("full_after_4", 64'(full), 64'd1);
    cyc();
    push = 1'b0;
    neg();
    chk("full_after_overflow", 64'(full), 64'd1);
    chk("valid_when_full", 64'(lq_valid), 64'd1);
    cyc();
    lq_ack = 1'b1;
    repeat (4) cyc();
    lq_ack = 1'b0;
    neg();
    chk("drained_empty", 64'(empty), 64'd1);
    cyc();

    // Blocked head until matching store retires; younger load waits behind it
    set_push(8'd5, 1'b1, 2'd2, 1'b1);
    cyc();
    set_push(8'd6, 1'b0, 2'd0, 1'b1);
    cyc();
    push = 1'b0;
    neg();
    chk("blocked_head", 64'(lq_valid), 64'd0);
    cyc();
    sq_retire = 1'b1;
    sq_retire_idx = 2'd1;
    cyc();
    sq_retire = 1'b0;
    neg();
    chk("wrong_retire_idx", 64'(lq_valid), 64'd0);
    cyc();
    sq_retire = 1'b1;
    sq_retire_idx = 2'd2;
    neg();
    chk("retire_same_cycle", 64'(lq_valid), 64'd0);
    cyc();
    sq_retire = 1'b0;
    neg();
    chk("unblocked", 64'(lq_valid), 64'd1);
    cyc();
    lq_ack = 1'b1;
    cyc();
    cyc();
    lq_ack = 1'b0;
    neg();
    chk("after_unblock_empty", 64'(empty), 64'd1);
    cyc();

    // Collision resolved by a retire in the push cycle
    set_push(8'd7, 1'b1, 2'd3, 1'b1);
    sq_retire = 1'b1;
    sq_retire_idx = 2'd3;
    cyc();
    push = 1'b0;
    sq_retire = 1'b0;
    neg();
    chk("push_retire_clear", 64'(lq_valid), 64'd1);
    cyc();
    lq_ack = 1'b1;
    cyc();
    lq_ack = 1'b0;
    neg();
    chk("push_retire_empty", 64'(empty), 64'd1);
    cyc();

    // Hold count at 3 with push+ack across pointer wrap
    for (int i = 0; i < 3; i++) begin
      set_push(8'(8 + i), 1'b0, 2'd0, 1'b1);
      cyc();
    end
    for (int i = 0; i < 8; i++) begin
      set_push(8'(11 + i), 1'b0, 2'd0, 1'b1);
      lq_ack = 1'b1;
      neg();
      chk("steady_not_empty", 64'(empty), 64'd0);
      chk("steady_not_full", 64'(full), 64'd0);
      cyc();
    end
    push = 1'b0;
    repeat (3) cyc();
    lq_ack = 1'b0;
    neg();
    chk("steady_drained", 64'(empty), 64'd1);
    cyc();

    // Flush wins over concurrent push and ack
    for (int i = 0; i < 3; i++) begin
      set_push(8'(32 + i), 1'b0, 2'd0, 1'b0);
      cyc();
    end
    set_push(8'h50, 1'b0, 2'd0, 1'b0);
    lq_ack = 1'b1;
    flush = 1'b1;
    cyc();
    push = 1'b0;
    lq_ack = 1'b0;
    flush = 1'b0;
    neg();
    chk("flush_empty", 64'(empty), 64'd1);
    chk("flush_valid", 64'(lq_valid), 64'd0);
    cyc();

    // Asynchronous reset mid-stream
    set_push(8'h60, 1'b0, 2'd0, 1'b0);
    cyc();
    set_push(8'h61, 1'b0, 2'd0, 1'b0);
    cyc();
    push = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_empty", 64'(empty), 64'd1);
    chk("async_rst_valid", 64'(lq_valid), 64'd0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Latency of a clean push into an empty queue
    set_push(8'h33, 1'b0, 2'd0, 1'b1);
    neg();
`ifdef LQ_BYPASS_EN
    chk("empty_push_same_cycle", 64'(lq_valid), 64'd1);
`else
    chk("empty_push_same_cycle", 64'(lq_valid), 64'd0);
`endif
    cyc();
    push = 1'b0;
    neg();
    chk("empty_push_next_cycle", 64'(lq_valid), 64'd1);
    cyc();
    lq_ack = 1'b1;
    cyc();
    lq_ack = 1'b0;
    neg();
    chk("latency_drained", 64'(empty), 64'd1);
    cyc();

`ifdef LQ_BYPASS_EN
    set_push(8'd9, 1'b0, 2'd0, 1'b1);
    lq_ack = 1'b1;
    neg();
    chk("bypass_valid", 64'(lq_valid), 64'd1);
    chk("bypass_id", 64'(lq_entry.id), 64'd9);
    cyc();
    push = 1'b0;
    lq_ack = 1'b0;
    neg();
    chk("bypass_count0", 64'(empty), 64'd1);
    cyc();
`endif

    chk("scoreboard_drained", 64'(exp_e.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
